// File: rtl/logic_resp_checker_pkg.sv
// Shared types and the reference function for the response checker.
// Purely declarative: no logic, no latency, no flow control.
// The exp_result() helper is evaluated combinationally by the checker.
package logic_chk_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int OP_AND  = 0;
   localparam int OP_OR   = 1;
   localparam int OP_XOR  = 2;
   localparam int OP_NAND = 3;

   // Operands are zero-extended by the caller; the caller truncates the result.
   function automatic logic [63:0] exp_result(input int op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NAND: return ~(a & b);
         default: return a & b;
      endcase
   endfunction

endpackage

// File: rtl/logic_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count visible 1 cycle after inc.
// No flow control: inc is ignored once the counter holds all ones.
module resp_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/logic_resp_checker.sv
// Response checker: recomputes OP(a,b), counts pass/fail, keeps the first mismatch and a verdict.
// Latency: 1 cycle from accept to counter update; done 2 cycles after the last accept.
// Backpressure: smp_ready only while running and short of num_samples; no other stall.
module logic_resp_checker
   import logic_chk_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1023,
   parameter int OP      = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             smp_valid,
   output logic             smp_ready,
   input  logic [WIDTH-1:0] smp_a,
   input  logic [WIDTH-1:0] smp_b,
   input  logic [WIDTH-1:0] smp_result,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [WIDTH-1:0] first_fail_exp,
   output logic [WIDTH-1:0] first_fail_got
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t           state;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] acc_q;
   logic [CNT_W-1:0] acc_nxt;
   logic [WD_W-1:0]  wd_q;
   logic [WD_W:0]    wd_inc;

   logic             s1_vld;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_r;
   logic [CNT_W-1:0] s1_idx;
   logic [WIDTH-1:0] s1_exp;

   logic accept;
   logic honour;
   logic run_done;
   logic wd_expire;
   logic mismatch;
   logic pass_inc;

   assign smp_ready = (state == RUN) && (acc_q < num_q);
   assign accept    = smp_valid && smp_ready;
   assign honour    = start && ((state == IDLE) || (state == DONE));
   assign acc_nxt   = accept ? acc_q + CNT_W'(1) : acc_q;
   assign run_done  = (acc_nxt == num_q);
   assign wd_inc    = {1'b0, wd_q} + (WD_W+1)'(1);
   assign wd_expire = !accept && (wd_inc >= (WD_W+1)'(TIMEOUT));

   assign s1_exp    = WIDTH'(exp_result(OP, 64'(s1_a), 64'(s1_b)));
   assign mismatch  = s1_vld && (s1_r != s1_exp);
   assign pass_inc  = s1_vld && !mismatch;

   resp_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (honour),
      .inc   (pass_inc),
      .cnt   (pass_cnt)
   );

   resp_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (honour),
      .inc   (mismatch),
      .cnt   (fail_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         num_q          <= '0;
         acc_q          <= '0;
         wd_q           <= '0;
         s1_vld         <= 1'b0;
         s1_a           <= '0;
         s1_b           <= '0;
         s1_r           <= '0;
         s1_idx         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         first_fail_idx <= '0;
         first_fail_exp <= '0;
         first_fail_got <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_a   <= smp_a;
            s1_b   <= smp_b;
            s1_r   <= smp_result;
            s1_idx <= acc_q;
         end
         if (mismatch && (fail_cnt == '0)) begin
            first_fail_idx <= s1_idx;
            first_fail_exp <= s1_exp;
            first_fail_got <= s1_r;
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= RUN;
                  num_q          <= num_samples;
                  acc_q          <= '0;
                  wd_q           <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  timeout        <= 1'b0;
                  first_fail_idx <= '0;
                  first_fail_exp <= '0;
                  first_fail_got <= '0;
               end
            end
            RUN: begin
               acc_q <= acc_nxt;
               wd_q  <= accept ? '0 : wd_inc[WD_W-1:0];
               // Completing the sample count takes priority over a coincident watchdog expiry.
               if (run_done) begin
                  state <= DRAIN;
               end else if (wd_expire) begin
                  state   <= DRAIN;
                  timeout <= 1'b1;
               end
            end
            DRAIN: begin
               // No accepts here, so the compare stage is always empty after this edge;
               // the verdict folds in the compare retiring in this same cycle.
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (fail_cnt == '0) && !mismatch && !timeout;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_resp_checker.sv
// Bench for logic_resp_checker: directed vector table, multi-cycle corner sequences,
// and randomized runs on all four operations against a queue-based reference model.
module tb_logic_resp_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Directed stimulus shared by the WIDTH=1 / CNT_W=16 and CNT_W=2 instances
   logic        d_start, d_valid, d_a, d_b, d_res;
   logic [15:0] d_num;
   logic        d_ready, d_busy, d_done, d_pass, d_to;
   logic [15:0] d_pc, d_fc, d_ffi;
   logic        d_ffe, d_ffg;
   logic        c_ready, c_busy, c_done, c_pass, c_to;
   logic [1:0]  c_pc, c_fc, c_ffi;
   logic        c_ffe, c_ffg;

   // Random stimulus shared by four instances, one per operation
   logic        r_start, r_valid;
   logic [7:0]  r_num;
   logic [3:0]  r_a, r_b, r_res;
   logic        r_ready [4];
   logic        r_busy [4];
   logic        r_done [4];
   logic        r_pass [4];
   logic        r_to [4];
   logic [7:0]  r_pc [4];
   logic [7:0]  r_fc [4];
   logic [7:0]  r_ffi [4];
   logic [3:0]  r_ffe [4];
   logic [3:0]  r_ffg [4];

   logic_resp_checker #(.WIDTH(1), .CNT_W(16), .TIMEOUT(8), .OP(0)) u_d (
      .clk(clk), .rst_n(rst_n), .start(d_start), .num_samples(d_num),
      .smp_valid(d_valid), .smp_ready(d_ready), .smp_a(d_a), .smp_b(d_b), .smp_result(d_res),
      .busy(d_busy), .done(d_done), .pass(d_pass), .timeout(d_to),
      .pass_cnt(d_pc), .fail_cnt(d_fc), .first_fail_idx(d_ffi),
      .first_fail_exp(d_ffe), .first_fail_got(d_ffg));

   logic_resp_checker #(.WIDTH(1), .CNT_W(2), .TIMEOUT(8), .OP(0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(d_start), .num_samples(d_num[1:0]),
      .smp_valid(d_valid), .smp_ready(c_ready), .smp_a(d_a), .smp_b(d_b), .smp_result(d_res),
      .busy(c_busy), .done(c_done), .pass(c_pass), .timeout(c_to),
      .pass_cnt(c_pc), .fail_cnt(c_fc), .first_fail_idx(c_ffi),
      .first_fail_exp(c_ffe), .first_fail_got(c_ffg));

   for (genvar g = 0; g < 4; g++) begin : g_r
      logic_resp_checker #(.WIDTH(4), .CNT_W(8), .TIMEOUT(6), .OP(g)) u_r (
         .clk(clk), .rst_n(rst_n), .start(r_start), .num_samples(r_num),
         .smp_valid(r_valid), .smp_ready(r_ready[g]), .smp_a(r_a), .smp_b(r_b), .smp_result(r_res),
         .busy(r_busy[g]), .done(r_done[g]), .pass(r_pass[g]), .timeout(r_to[g]),
         .pass_cnt(r_pc[g]), .fail_cnt(r_fc[g]), .first_fail_idx(r_ffi[g]),
         .first_fail_exp(r_ffe[g]), .first_fail_got(r_ffg[g]));
   end

   typedef struct {
      logic a;
      logic b;
      logic r;
      logic good;
   } vec_t;
   vec_t tv [8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] n);
      d_num   = n;
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
   endtask

   task automatic send(input logic a, input logic b, input logic r);
      d_valid = 1'b1;
      d_a     = a;
      d_b     = b;
      d_res   = r;
      chk("d_ready_on_send", 32'(d_ready), 1);
      tick();
      d_valid = 1'b0;
   endtask

   function automatic logic [3:0] ref_op(input int op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         1:       return a | b;
         2:       return a ^ b;
         3:       return ~(a & b);
         default: return a & b;
      endcase
   endfunction

   int         epc, efc, effi, acc, idle, cyc, num, p, pick, n;
   logic       leaving, to, exp_rdy, acc_now;
   logic [3:0] e, effe, effg;
   logic [3:0] qa [$];
   logic [3:0] qb [$];
   logic [3:0] qr [$];

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      tv[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
      tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
      tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tv[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tv[6] = '{1'b1, 1'b1, 1'b1, 1'b1};
      tv[7] = '{1'b1, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      d_start = 0; d_valid = 0; d_a = 0; d_b = 0; d_res = 0; d_num = '0;
      r_start = 0; r_valid = 0; r_a = '0; r_b = '0; r_res = '0; r_num = '0;
      tick(); tick();
      chk("rst_ready", 32'(d_ready), 0);
      chk("rst_busy_done_pass_to", {28'd0, d_busy, d_done, d_pass, d_to}, 0);
      chk("rst_counts", 32'(d_pc) | 32'(d_fc) | 32'(d_ffi), 0);
      rst_n = 1'b1;
      tick();

      // Vector table: counters trail each accept by one cycle
      start_run(8);
      epc = 0; efc = 0;
      for (int i = 0; i < 8; i++) begin
         send(tv[i].a, tv[i].b, tv[i].r);
         chk("tbl_pass_cnt", 32'(d_pc), 32'(epc));
         chk("tbl_fail_cnt", 32'(d_fc), 32'(efc));
         if (tv[i].good) epc++; else efc++;
      end
      tick();
      chk("tbl_done", 32'(d_done), 1);
      chk("tbl_pass_cnt_final", 32'(d_pc), 32'(epc));
      chk("tbl_fail_cnt_final", 32'(d_fc), 32'(efc));
      chk("tbl_first_idx", 32'(d_ffi), 1);
      chk("tbl_first_got", 32'(d_ffg), 1);
      chk("tbl_pass", 32'(d_pass), 0);

      // Three good samples back-to-back
      start_run(3);
      send(0, 0, 0); send(0, 1, 0); send(1, 1, 1);
      chk("ok3_drain_busy", 32'(d_busy), 1);
      chk("ok3_drain_done", 32'(d_done), 0);
      tick();
      chk("ok3_done", 32'(d_done), 1);
      chk("ok3_pass", 32'(d_pass), 1);
      chk("ok3_pass_cnt", 32'(d_pc), 3);
      chk("ok3_fail_cnt", 32'(d_fc), 0);

      // Second sample wrong
      start_run(3);
      send(0, 0, 0); send(0, 1, 1); send(1, 1, 1);
      tick();
      chk("bad2_fail_cnt", 32'(d_fc), 1);
      chk("bad2_first_idx", 32'(d_ffi), 1);
      chk("bad2_first_exp", 32'(d_ffe), 0);
      chk("bad2_first_got", 32'(d_ffg), 1);
      chk("bad2_pass", 32'(d_pass), 0);

      // Watchdog abort
      start_run(4);
      send(0, 0, 0); send(1, 1, 1);
      n = 1;
      while (!d_done && n < 40) begin
         tick();
         n++;
      end
      chk("to_done_latency", 32'(n), 10);
      chk("to_timeout", 32'(d_to), 1);
      chk("to_pass", 32'(d_pass), 0);
      chk("to_pass_cnt", 32'(d_pc), 2);

      // Zero-sample run
      start_run(0);
      chk("z_ready_c1", 32'(d_ready), 0);
      chk("z_done_c1", 32'(d_done), 0);
      tick();
      chk("z_ready_c2", 32'(d_ready), 0);
      chk("z_done_c2", 32'(d_done), 0);
      tick();
      chk("z_done", 32'(d_done), 1);
      chk("z_pass", 32'(d_pass), 1);
      chk("z_timeout_cleared", 32'(d_to), 0);
      chk("z_counts", 32'(d_pc) | 32'(d_fc), 0);

      // CNT_W=2: three fails, restart from DONE, start ignored in RUN
      start_run(3);
      send(1, 1, 0); send(0, 0, 1); send(1, 0, 1);
      tick();
      chk("c_fail_cnt", 32'(c_fc), 3);
      chk("c_done", 32'(c_done), 1);
      chk("c_pass", 32'(c_pass), 0);
      chk("c_first_exp", 32'(c_ffe), 1);
      start_run(3);
      chk("c_restart_busy", 32'(c_busy), 1);
      chk("c_restart_done", 32'(c_done), 0);
      chk("c_restart_fail_cnt", 32'(c_fc), 0);
      chk("c_restart_first_exp", 32'(c_ffe), 0);
      chk("c_restart_ready", 32'(c_ready), 1);
      start_run(0);
      chk("c_ignore_start_ready", 32'(c_ready), 1);
      chk("c_ignore_start_busy", 32'(c_busy), 1);
      send(0, 0, 0); send(1, 1, 1); send(1, 0, 0);
      tick();
      chk("c_rerun_pass_cnt", 32'(c_pc), 3);
      chk("c_rerun_pass", 32'(c_pass), 1);

      // Reset mid-run, then a clean run from index 0
      start_run(4);
      send(1, 1, 1); send(0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("mrst_flags", {27'd0, d_ready, d_busy, d_done, d_pass, d_to}, 0);
      chk("mrst_counts", 32'(d_pc) | 32'(d_fc), 0);
      tick();
      rst_n = 1'b1;
      tick();
      start_run(2);
      send(1, 1, 0); send(1, 1, 1);
      tick();
      chk("mrst_rerun_done", 32'(d_done), 1);
      chk("mrst_rerun_counts", {d_pc, d_fc}, {16'd1, 16'd1});
      chk("mrst_rerun_first_idx", 32'(d_ffi), 0);
      chk("mrst_rerun_first_exp_got", {30'd0, d_ffe, d_ffg}, 2);

      // Randomized runs on all four operations
      for (int run = 0; run < 24; run++) begin
         num = $urandom_range(0, 12);
         p = (run % 3 == 0) ? 2 : ((run % 3 == 1) ? 7 : 10);
         qa.delete(); qb.delete(); qr.delete();
         r_num = 8'(num);
         r_start = 1'b1;
         tick();
         r_start = 1'b0;
         acc = 0; idle = 0; cyc = 0; leaving = 0; to = 0;
         while (!leaving && cyc < 200) begin
            exp_rdy = (acc < num);
            for (int g = 0; g < 4; g++) chk($sformatf("rnd_ready_op%0d", g), 32'(r_ready[g]), 32'(exp_rdy));
            r_valid = ($urandom_range(0, 9) < p);
            r_a = 4'($urandom);
            r_b = 4'($urandom);
            pick = $urandom_range(0, 4);
            r_res = (pick == 4) ? 4'($urandom) : ref_op(pick, r_a, r_b);
            acc_now = r_valid && exp_rdy;
            if (acc_now) begin
               qa.push_back(r_a); qb.push_back(r_b); qr.push_back(r_res);
               acc++;
               idle = 0;
            end else begin
               idle++;
            end
            if (acc == num) leaving = 1;
            else if (idle >= 6) begin leaving = 1; to = 1; end
            tick();
            cyc++;
         end
         r_valid = 1'b0;
         chk("rnd_run_bound", 32'(leaving), 1);
         chk("rnd_drain_done", 32'(r_done[0]), 0);
         tick();
         for (int g = 0; g < 4; g++) begin
            epc = 0; efc = 0; effi = 0; effe = '0; effg = '0;
            for (int i = 0; i < qa.size(); i++) begin
               e = ref_op(g, qa[i], qb[i]);
               if (qr[i] == e) epc++;
               else begin
                  if (efc == 0) begin effi = i; effe = e; effg = qr[i]; end
                  efc++;
               end
            end
            chk($sformatf("rnd_done_op%0d", g), 32'(r_done[g]), 1);
            chk($sformatf("rnd_pass_cnt_op%0d", g), 32'(r_pc[g]), 32'(epc));
            chk($sformatf("rnd_fail_cnt_op%0d", g), 32'(r_fc[g]), 32'(efc));
            chk($sformatf("rnd_timeout_op%0d", g), 32'(r_to[g]), 32'(to));
            chk($sformatf("rnd_pass_op%0d", g), 32'(r_pass[g]), 32'((efc == 0) && !to));
            if (efc > 0) begin
               chk($sformatf("rnd_first_idx_op%0d", g), 32'(r_ffi[g]), 32'(effi));
               chk($sformatf("rnd_first_exp_op%0d", g), 32'(r_ffe[g]), 32'(effe));
               chk($sformatf("rnd_first_got_op%0d", g), 32'(r_ffg[g]), 32'(effg));
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
